rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//   N-to-1 stream multiplexer, the merging counterpart of demux. Collects NUM_ELEM valid/ready
//   input streams and forwards one beat per cycle to a single registered output, choosing
//   among requesters by round-robin. Also reports which input each output beat came from,
//   so a downstream demux can route responses back to that input.
// PARAMETERS
//   NUM_ELEM   = 4 : number of input streams (>= 2, need not be a power of two)
//   DATA_WIDTH = 8 : payload width per stream
// PORTS
//   clk_i        in   1                    : clock, rising edge
//   arst_i       in   1                    : asynchronous reset, active-high
//   in_data_i    in   NUM_ELEM*DATA_WIDTH  : input payloads; stream k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_valid_i   in   NUM_ELEM             : per-stream valid
//   in_ready_o   out  NUM_ELEM             : per-stream ready, at most one bit high
//   out_data_o   out  DATA_WIDTH           : registered output payload
//   out_sel_o    out  $clog2(NUM_ELEM)     : source index of the current out_data_o
//   out_valid_o  out  1                    : output valid
//   out_ready_i  in   1                    : downstream ready
// BEHAVIOUR
//   Reset: out_valid_o=0, out_data_o=0, out_sel_o=0, last-grant pointer = NUM_ELEM-1.
//     Reset asserted mid-transfer drops the held beat immediately.
//   Handshake: transfer on stream k when in_valid_i[k] && in_ready_o[k]. Output transfer
//     when out_valid_o && out_ready_i.
//     - Once asserted, out_valid_o and the output payload/sel are held stable until the
//       output transfer completes.
//   load = !out_valid_o || out_ready_i. This is full throughput, 1 beat/cycle.
//   Arbitration (combinational):
//     - Search indices last+1, last+2, ... with wrap-around from NUM_ELEM-1 to 0.
//     - The first k with in_valid_i[k]=1 is the grant.
//     - in_ready_o = onehot(grant) when load && any valid; otherwise all zero.
//     - in_ready_o depends combinationally on out_ready_i; there is no path from
//       in_ready_o back to in_valid_i.
//   On each rising edge when load=1:
//     - Any valid: out_data_o <= in_data[grant], out_sel_o <= grant, out_valid_o <= 1,
//       last <= grant.
//     - No valid: out_valid_o <= 0. Data, sel and last are unchanged.
//   Latency: 1 cycle from input transfer to out_valid_o.
//   Pointer rule: the pointer moves only on a granted transfer. A stalled output
//     (out_valid_o && !out_ready_i) freezes the pointer and holds every in_ready_o low.
//   Fairness: with all inputs continuously valid and out_ready_i=1, grants cycle
//     0,1,..,N-1,0,... Each requester waits at most NUM_ELEM-1 grants.
//   Boundaries:
//     - Single requester: granted every cycle regardless of the pointer.
//     - Requester dropping valid before its grant: skipped, no penalty.
//     - Simultaneous output transfer and new grant in one cycle: new beat replaces the
//       old one, with no bubble.
//     - Non-power-of-two NUM_ELEM: indices >= NUM_ELEM are never granted.
//   Width rule: index arithmetic is modulo NUM_ELEM, not modulo 2**$clog2(NUM_ELEM).
// TESTING
//   1. Reset: arst_i=1 pulse with all valids high -> out_valid_o=0, in_ready_o=0 while in
//      reset. First post-reset grant goes to index 0.
//   2. All 4 valid, data k=8'hA0+k, out_ready_i=1 for 8 cycles -> out_sel_o sequence
//      0,1,2,3,0,1,2,3 and matching data A0..A3, 1 beat/cycle.
//   3. Backpressure: out_ready_i=0 for 5 cycles with beat sel=2 held -> out_data_o/out_sel_o
//      stable, in_ready_o=0. On release the next grant is 3.
//   4. Sparse: only in_valid_i[1] and [3] high, N=4 -> grants alternate 1,3,1,3. Index 2
//      added mid-run is served right after 1.
//   5. Reset mid-stall: out_valid_o=1, out_ready_i=0, then assert arst_i -> out_valid_o=0
//      asynchronously, the beat is never delivered, and the pointer returns to NUM_ELEM-1.
//   6. NUM_ELEM=3, all valid -> sel sequence 0,1,2,0,1,2. Index 3 is never produced.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready merge with round-robin arbitration and a
// registered output stage that also reports the source index of each beat.
module rr_stream_mux #(
   parameter  int NUM_ELEM   = 4,
   parameter  int DATA_WIDTH = 8,
   localparam int SEL_W      = $clog2(NUM_ELEM)
) (
   input  logic                           clk_i,
   input  logic                           arst_i,
   input  logic [NUM_ELEM*DATA_WIDTH-1:0] in_data_i,
   input  logic [NUM_ELEM-1:0]            in_valid_i,
   output logic [NUM_ELEM-1:0]            in_ready_o,
   output logic [DATA_WIDTH-1:0]          out_data_o,
   output logic [SEL_W-1:0]               out_sel_o,
   output logic                           out_valid_o,
   input  logic                           out_ready_i
);
   logic [SEL_W-1:0]      r_last;
   logic [SEL_W-1:0]      r_sel;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   logic [DATA_WIDTH-1:0] w_in_data [NUM_ELEM];
   logic [SEL_W:0]        w_sum     [NUM_ELEM];
   logic [SEL_W-1:0]      w_cand    [NUM_ELEM];
   logic [SEL_W-1:0]      w_grant;
   logic                  w_any;
   logic                  w_load;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_ELEM; gi++) begin : g_cand
         assign w_in_data[gi] = in_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
         // Search slot gi holds (last+1+gi) mod NUM_ELEM; folding by one subtraction keeps non-power-of-two sizes in range.
         assign w_sum[gi]     = {1'b0, r_last} + (SEL_W+1)'(gi + 1);
         assign w_cand[gi]    = (w_sum[gi] >= (SEL_W+1)'(NUM_ELEM))
                                ? SEL_W'(w_sum[gi] - (SEL_W+1)'(NUM_ELEM))
                                : w_sum[gi][SEL_W-1:0];
      end
   endgenerate

   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      for (int i = NUM_ELEM - 1; i >= 0; i--) begin
         if (in_valid_i[w_cand[i]]) begin
            w_grant = w_cand[i];
            w_any   = 1'b1;
         end
      end
   end

   assign w_load     = !r_valid || out_ready_i;
   assign in_ready_o = (w_load && w_any && !arst_i) ? (NUM_ELEM'(1) << w_grant) : '0;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_last  <= SEL_W'(NUM_ELEM - 1);
      end else if (w_load) begin
         if (w_any) begin
            r_valid <= 1'b1;
            r_data  <= w_in_data[w_grant];
            r_sel   <= w_grant;
            r_last  <= w_grant;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid_o = r_valid;
   assign out_data_o  = r_data;
   assign out_sel_o   = r_sel;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed table, hand sequences for stall/reset corners,
// and randomized traffic against a round-robin reference model.
module tb_rr_stream_mux;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_valid;
   logic        out_ready;

   logic [23:0] d3;
   logic [2:0]  v3;
   logic [2:0]  rdy3;
   logic [7:0]  od3;
   logic [1:0]  os3;
   logic        ov3;
   logic        r3;

   rr_stream_mux #(.NUM_ELEM(4), .DATA_WIDTH(8)) dut (
      .clk_i(clk), .arst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .out_data_o(out_data), .out_sel_o(out_sel),
      .out_valid_o(out_valid), .out_ready_i(out_ready));

   rr_stream_mux #(.NUM_ELEM(3), .DATA_WIDTH(8)) dut3 (
      .clk_i(clk), .arst_i(rst), .in_data_i(d3), .in_valid_i(v3),
      .in_ready_o(rdy3), .out_data_o(od3), .out_sel_o(os3),
      .out_valid_o(ov3), .out_ready_i(r3));

   int n_vec = 0;
   int n_err = 0;

   // Reference state: the held output beat and the index of the last grant.
   bit         m_valid;
   logic [7:0] m_data;
   int         m_sel;
   int         m_last;

   typedef struct {
      logic [3:0]  valid;
      logic        ready;
      logic [31:0] data;
      logic [3:0]  exp_rdy;
      logic        exp_valid;
      logic [1:0]  exp_sel;
      logic [7:0]  exp_data;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int m_pick(input logic [3:0] v, input int last);
      for (int off = 1; off <= N; off++) begin
         int k;
         k = (last + off) % N;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_last  = N - 1;
   endtask

   task automatic step(input logic [3:0] v, input logic [31:0] d, input logic rdy,
                       output logic [3:0] rdy_seen);
      int         g;
      bit         load;
      logic [3:0] exp_rdy;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      #1;
      load     = !m_valid || rdy;
      g        = m_pick(v, m_last);
      exp_rdy  = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
      rdy_seen = in_ready;
      chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
      @(posedge clk);
      if (load) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = d[g*8 +: 8];
            m_sel   = g;
            m_last  = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
      $display("cycle v=%b rdy=%b in_ready=%b -> out_valid=%b sel=%0d data=%h",
               v, rdy, rdy_seen, out_valid, out_sel, out_data);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_sel", {30'd0, out_sel}, m_sel);
      chk("out_data", {24'd0, out_data}, {24'd0, m_data});
   endtask

   logic [3:0]  rs;
   logic [31:0] base;

   initial begin
      base = 32'hA3A2A1A0;
      for (int i = 0; i < 8; i++) begin
         tbl[i].valid     = 4'hF;
         tbl[i].ready     = 1'b1;
         tbl[i].data      = base;
         tbl[i].exp_rdy   = 4'(1 << (i % 4));
         tbl[i].exp_valid = 1'b1;
         tbl[i].exp_sel   = 2'(i % 4);
         tbl[i].exp_data  = 8'hA0 + 8'(i % 4);
      end

      // Reset with every requester valid
      rst = 1'b1; in_valid = 4'hF; in_data = base; out_ready = 1'b1;
      v3 = 3'b000; d3 = 24'hC2C1C0; r3 = 1'b1;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {28'd0, in_ready}, 32'd0);
      chk("rst_sel", {30'd0, out_sel}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      rst = 1'b0;

      // Full-rate rotation 0..3 twice, first grant to index 0
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].valid, tbl[i].data, tbl[i].ready, rs);
         chk("tbl_rdy", {28'd0, rs}, {28'd0, tbl[i].exp_rdy});
         chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
         chk("tbl_sel", {30'd0, out_sel}, {30'd0, tbl[i].exp_sel});
         chk("tbl_data", {24'd0, out_data}, {24'd0, tbl[i].exp_data});
      end

      // Backpressure with the sel=2 beat held
      for (int i = 0; i < 3; i++) step(4'hF, base, 1'b1, rs);
      chk("bp_start_sel", {30'd0, out_sel}, 32'd2);
      for (int i = 0; i < 5; i++) begin
         step(4'hF, base, 1'b0, rs);
         chk("bp_hold_ready", {28'd0, rs}, 32'd0);
         chk("bp_hold_sel", {30'd0, out_sel}, 32'd2);
         chk("bp_hold_data", {24'd0, out_data}, 32'hA2);
      end
      step(4'hF, base, 1'b1, rs);
      chk("bp_next", {28'd0, rs}, 32'b1000);

      // Sparse requesters 1 and 3, then 2 joins right after 1 is served
      for (int i = 0; i < 4; i++) begin
         step(4'b1010, base, 1'b1, rs);
         chk("sparse_grant", {28'd0, rs}, (i % 2 == 0) ? 32'b0010 : 32'b1000);
      end
      step(4'b1010, base, 1'b1, rs);
      chk("sparse_pre", {28'd0, rs}, 32'b0010);
      step(4'b1110, base, 1'b1, rs);
      chk("sparse_join", {28'd0, rs}, 32'b0100);

      // Single requester granted every cycle
      for (int i = 0; i < 3; i++) begin
         step(4'b0100, base, 1'b1, rs);
         chk("single", {28'd0, rs}, 32'b0100);
      end

      // Reset during a stall drops the held beat and rewinds the pointer
      step(4'hF, base, 1'b1, rs);
      step(4'hF, base, 1'b0, rs);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_ready", {28'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_reset();
      step(4'hF, base, 1'b1, rs);
      chk("post_rst_grant", {28'd0, rs}, 32'b0001);
      chk("post_rst_data", {24'd0, out_data}, 32'hA0);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         logic [3:0]  rv;
         logic [31:0] rd;
         logic        rr;
         rv = 4'($urandom);
         rd = $urandom;
         rr = ($urandom_range(0, 3) != 0);
         step(rv, rd, rr, rs);
      end
      in_valid = 4'h0;

      // Three-input instance: wraps 2 -> 0, index 3 never appears
      v3 = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("n3_ready", {29'd0, rdy3}, 32'(1 << (i % 3)));
         @(posedge clk);
         #1;
         $display("n3 cycle %0d: out_valid=%b sel=%0d data=%h", i, ov3, os3, od3);
         chk("n3_valid", {31'd0, ov3}, 32'd1);
         chk("n3_sel", {30'd0, os3}, 32'(i % 3));
         chk("n3_data", {24'd0, od3}, 32'hC0 + 32'(i % 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
